tick_pulse_generator: RTL and testbench

TICK_PULSE_GENERATOR -- requirements
Module: tick_pulse_generator

---
 rtl/tick_pulse_generator.sv | 126 ++++++++++++
 tb/tb_tick_pulse_generator.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/tick_pulse_generator.sv
// Tick source for a BCD display counter: free-running divider with run/pause
// and single-step pushbuttons, each synchronized, debounced and edge-detected.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_RUN   | divider advances, tick on the DIV-1 count
// S_PAUSE | divider held, tick only as a single step from KEY2
module tick_pulse_generator #(
  parameter int CLK_HZ          = 50_000_000,
  parameter int TICK_HZ         = 1,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic CLOCK_50,
  input  logic KEY0,
  input  logic KEY1,
  input  logic KEY2,
  output logic tick,
  output logic running
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int DIV_W = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int DB_W  = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

  if (DIV < 2) begin : g_bad_div
    $error("tick_pulse_generator: CLK_HZ/TICK_HZ must be at least 2");
  end

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("tick_pulse_generator: DEBOUNCE_CYCLES must be at least 1");
  end

  typedef enum logic {
    S_PAUSE = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  // Bit 0 is the run/pause key, bit 1 the single-step key.
  logic [1:0]      key_raw;
  logic [1:0]      sync1_q;
  logic [1:0]      sync2_q;
  logic [1:0]      level_q;
  logic [1:0]      press_q;
  logic [DB_W-1:0] cnt_q [0:1];

  assign key_raw = {KEY2, KEY1};

  always_ff @(posedge CLOCK_50) begin
    if (KEY0) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      press_q <= '0;
      for (int k = 0; k < 2; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      for (int k = 0; k < 2; k++) begin
        press_q[k] <= 1'b0;
        if (sync2_q[k] == level_q[k]) begin
          cnt_q[k] <= '0;
        end else if (cnt_q[k] == DB_LAST) begin
          // Level flips on the last qualifying sample; a rising flip is the press.
          level_q[k] <= sync2_q[k];
          cnt_q[k]   <= '0;
          press_q[k] <= sync2_q[k];
        end else begin
          cnt_q[k] <= cnt_q[k] + DB_W'(1);
        end
      end
    end
  end

  state_t           state_q;
  state_t           state_d;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic             tick_q;
  logic             tick_d;
  logic             running_q;
  logic             toggle;
  logic             step;

  always_comb begin
    toggle  = press_q[0];
    step    = 1'b0;
    state_d = state_q;
    div_d   = div_q;

    if (toggle) begin
      state_d = (state_q == S_RUN) ? S_PAUSE : S_RUN;
    end

    if (state_q == S_RUN) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    end else begin
      step = press_q[1] && !toggle;
    end

    // Registered look-ahead: tick_q lines up with the cycle div_q sits at DIV-1 in RUN.
    tick_d = ((state_d == S_RUN) && (div_d == DIV_LAST)) || step;
  end

  always_ff @(posedge CLOCK_50) begin
    if (KEY0) begin
      state_q   <= S_RUN;
      div_q     <= '0;
      tick_q    <= 1'b0;
      running_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      tick_q    <= tick_d;
      running_q <= (state_d == S_RUN);
    end
  end

  assign tick    = tick_q;
  assign running = running_q;

endmodule

// File: tb/tb_tick_pulse_generator.sv
// Bench for tick_pulse_generator with DIV=10 and a 4-sample debounce.
// Per-edge vectors expect the outputs seen right after edge e (consumed at edge e+1).
module tb_tick_pulse_generator;

  localparam int CLK_HZ          = 10;
  localparam int TICK_HZ         = 1;
  localparam int DEBOUNCE_CYCLES = 4;

  logic clk  = 1'b0;
  logic key0 = 1'b1;
  logic key1 = 1'b0;
  logic key2 = 1'b0;
  logic tick;
  logic running;

  always #5 clk = ~clk;

  tick_pulse_generator #(
    .CLK_HZ(CLK_HZ),
    .TICK_HZ(TICK_HZ),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) dut (
    .CLOCK_50(clk),
    .KEY0(key0),
    .KEY1(key1),
    .KEY2(key2),
    .tick(tick),
    .running(running)
  );

  typedef struct {
    string name;
    int    edge_no;
    logic  k0;
    logic  k1;
    logic  k2;
    logic  exp_tick;
    logic  exp_run;
  } vec_t;

  typedef struct {
    string      name;
    int         edge_no;
    logic [1:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic bit in_rng(int e, int lo, int hi);
    return (e >= lo) && (e <= hi);
  endfunction

  task automatic add(string name, int e, logic k0, logic k1, logic k2, logic t, logic r);
    vec_t v;
    v.name     = name;
    v.edge_no  = e;
    v.k0       = k0;
    v.k1       = k1;
    v.k2       = k2;
    v.exp_tick = t;
    v.exp_run  = r;
    vecs.push_back(v);
  endtask

  task automatic check_out();
    sb_t s;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: output observed with no expectation queued");
    end else begin
      s = sb_q.pop_front();
      if ({tick, running} !== s.exp) begin
        n_bad++;
        $display("FAIL %s edge %0d: tick,running = %b%b, expected %b%b",
                 s.name, s.edge_no, tick, running, s.exp[1], s.exp[0]);
      end
    end
  endtask

  task automatic apply(vec_t v);
    sb_t s;
    key0      = v.k0;
    key1      = v.k1;
    key2      = v.k2;
    s.name    = v.name;
    s.edge_no = v.edge_no;
    s.exp     = {v.exp_tick, v.exp_run};
    sb_q.push_back(s);
    @(negedge clk);
    check_out();
  endtask

  initial begin
    int   ticks;
    int   doubles;
    logic prev_tick;

    // Free run: ticks presented to edges 10, 20, 30.
    add("free_run", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int e = 1; e <= 35; e++)
      add("free_run", e, 1'b0, 1'b0, 1'b0, (e % 10 == 9), 1'b1);

    // Bounce 1,0,1,0 in 2-cycle steps, then held: a single toggle to PAUSE.
    add("bounce", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int e = 1; e <= 26; e++)
      add("bounce", e, 1'b0,
          (e == 1) || (e == 2) || (e == 5) || (e == 6) || in_rng(e, 9, 16),
          1'b0, (e == 9), !(e >= 15));

    // Pause with the divider held at 6, resume 20+ cycles later.
    add("pause_resume", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int e = 1; e <= 50; e++)
      add("pause_resume", e, 1'b0, in_rng(e, 10, 15) || in_rng(e, 36, 41), 1'b0,
          (e == 9) || (e == 45), !in_rng(e, 16, 41));

    // Three single steps while paused, resume from 6, then a step press in RUN.
    add("single_step", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int e = 1; e <= 86; e++)
      add("single_step", e, 1'b0,
          in_rng(e, 10, 15) || in_rng(e, 56, 61),
          in_rng(e, 20, 25) || in_rng(e, 32, 37) || in_rng(e, 44, 49) || in_rng(e, 70, 75),
          (e == 9) || (e == 26) || (e == 38) || (e == 50) || (e == 65) || (e == 75) || (e == 85),
          !in_rng(e, 16, 61));

    // Coinciding presses while paused, then reset in the middle of a debounce.
    add("simul_reset", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int e = 1; e <= 50; e++)
      add("simul_reset", e, (e == 34),
          in_rng(e, 10, 15) || in_rng(e, 20, 25) || in_rng(e, 32, 36),
          in_rng(e, 20, 25),
          (e == 9) || (e == 29) || (e == 43), !in_rng(e, 16, 25));

    // Pause lands on divider = 9: that tick still fires and the divider wraps.
    add("wrap_pause", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int e = 1; e <= 37; e++)
      add("wrap_pause", e, 1'b0, in_rng(e, 4, 9) || in_rng(e, 20, 25), 1'b0,
          (e == 9) || (e == 35), !in_rng(e, 10, 25));

    foreach (vecs[i]) apply(vecs[i]);

    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    // Long free run: ten single-cycle ticks in 100 cycles.
    key0 = 1'b1;
    key1 = 1'b0;
    key2 = 1'b0;
    @(negedge clk);
    key0      = 1'b0;
    ticks     = 0;
    doubles   = 0;
    prev_tick = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (tick) ticks++;
      if (tick && prev_tick) doubles++;
      prev_tick = tick;
    end
    n_cmp++;
    if (ticks != 10) begin
      n_bad++;
      $display("FAIL long_run_count: %0d ticks, expected 10", ticks);
    end
    n_cmp++;
    if (doubles != 0) begin
      n_bad++;
      $display("FAIL long_run_width: %0d back-to-back ticks, expected 0", doubles);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
